// File: rtl/io_input_port.sv
// io_input_port: byte-wide input FIFO port for the SAP3 core.
// An external source pushes bytes with a strobe. The core pops them, polls
// status and fill count, and may enable a level interrupt or flush the queue.
module io_input_port #(
   parameter int DEPTH     = 8,
   parameter int IRQ_LEVEL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_strobe,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic [1:0] rd_sel,
   input  logic       rd_en,
   input  logic       wr_en,
   input  logic [7:0] bus_in,
   output logic [7:0] out,
   output logic       irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] IRQ_CNT  = CW'(IRQ_LEVEL);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          irq_q, irq_d;

   logic full, empty, flush;
   logic data_rd, push, pop, ovf_set, udf_set, stat_clr;

   // Only the two control bits of the core bus are meaningful.
   logic bus_unused;
   assign bus_unused = ^bus_in[7:2];

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign flush = ctrl_q[1];

   // Next-state logic: push/pop decisions, sticky flags, flush and irq.
   always_comb begin
      data_rd  = rd_en & (rd_sel == 2'b00);
      stat_clr = rd_en & (rd_sel == 2'b01);
      // A pending flush swallows both sides of the queue for one cycle.
      push     = in_strobe & ~full & ~flush;
      pop      = data_rd & ~empty & ~flush;
      ovf_set  = in_strobe & full & ~flush;
      udf_set  = data_rd & empty & ~flush;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end

      // A set event in the clearing cycle keeps the flag asserted.
      ovf_d = (ovf_q & ~stat_clr) | ovf_set;
      udf_d = (udf_q & ~stat_clr) | udf_set;

      ctrl_d = ctrl_q;
      if (flush) ctrl_d[1] = 1'b0;
      if (wr_en) ctrl_d = bus_in[1:0];

      irq_d = ctrl_q[0] & (count_d >= IRQ_CNT);
   end

   // Control state; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         ctrl_q   <= 2'b00;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         ctrl_q   <= ctrl_d;
         irq_q    <= irq_d;
      end
   end

   // Storage array; contents after reset are don't-care.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // Read mux, combinational from registered state.
   always_comb begin
      case (rd_sel)
         2'b00:   out = empty ? 8'h00 : mem_q[rd_ptr_q];
         2'b01:   out = {4'b0000, ovf_q, udf_q, full, empty};
         2'b10:   out = 8'(count_q);
         default: out = {6'b000000, ctrl_q};
      endcase
   end

   assign in_ready = ~full;
   assign irq      = irq_q;

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed stimulus queues expected values,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_io_input_port;

   localparam int K_OUT = 0;
   localparam int K_IRQ = 1;
   localparam int K_RDY = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_strobe;
   logic [7:0] in_data;
   logic       in_ready;
   logic [1:0] rd_sel;
   logic       rd_en;
   logic       wr_en;
   logic [7:0] bus_in;
   logic [7:0] out_w;
   logic       irq;

   int         kind_q[$];
   logic [7:0] exp_q[$];
   string      name_q[$];
   logic       mon_req = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;

   io_input_port #(.DEPTH(8), .IRQ_LEVEL(4)) dut (
      .clk(clk), .rst(rst), .in_strobe(in_strobe), .in_data(in_data),
      .in_ready(in_ready), .rd_sel(rd_sel), .rd_en(rd_en), .wr_en(wr_en),
      .bus_in(bus_in), .out(out_w), .irq(irq)
   );

   always #5 clk = ~clk;

   // Monitor: compare one queued expectation per requested sample.
   always @(negedge clk) begin
      if (mon_req) begin
         n_tests++;
         if (kind_q.size() == 0) begin
            n_fail++;
            $display("FAIL monitor_underrun: sample requested with empty scoreboard");
         end else begin
            int         k;
            logic [7:0] e;
            logic [7:0] a;
            string      nm;
            k  = kind_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = (k == K_OUT) ? out_w : (k == K_IRQ) ? {7'd0, irq} : {7'd0, in_ready};
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s: got 8'h%02h expected 8'h%02h", nm, a, e);
            end
         end
      end
   end

   task automatic idle();
      in_strobe = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
   endtask

   // One clock of activity, then return inputs to idle.
   task automatic cyc(input logic st, input logic [7:0] d, input logic re,
                      input logic [1:0] sel, input logic we, input logic [7:0] b);
      in_strobe = st; in_data = d; rd_en = re; rd_sel = sel; wr_en = we; bus_in = b;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 2'b00, 1'b0, 8'h00);
   endtask

   task automatic pop();
      cyc(1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00);
   endtask

   // Queue an expectation and request one monitor sample (inputs idle).
   task automatic chk(input int k, input logic [1:0] sel, input logic [7:0] e, input string nm);
      idle();
      rd_sel = sel;
      kind_q.push_back(k);
      exp_q.push_back(e);
      name_q.push_back(nm);
      mon_req = 1'b1;
      @(negedge clk);
      #1;
      mon_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_strobe = 1'b1; in_data = 8'hEE;
      rd_en = 1'b0; rd_sel = 2'b00; wr_en = 1'b0; bus_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      // T1 reset
      chk(K_OUT, 2'b10, 8'h00, "t1_count");
      chk(K_OUT, 2'b01, 8'h01, "t1_status");
      chk(K_RDY, 2'b00, 8'h01, "t1_in_ready");
      chk(K_IRQ, 2'b00, 8'h00, "t1_irq");
      chk(K_OUT, 2'b00, 8'h00, "t1_data_empty");
      chk(K_OUT, 2'b11, 8'h00, "t1_ctrl");

      // T2 fill and drain
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      chk(K_OUT, 2'b10, 8'h08, "t2_count_full");
      chk(K_OUT, 2'b01, 8'h02, "t2_status_full");
      chk(K_RDY, 2'b00, 8'h00, "t2_in_ready_full");
      for (int i = 0; i < 8; i++) begin
         chk(K_OUT, 2'b00, 8'h10 + 8'(i), "t2_data");
         pop();
      end
      chk(K_OUT, 2'b01, 8'h01, "t2_status_empty");

      // T3 overflow
      for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
      push(8'hAA);
      chk(K_OUT, 2'b01, 8'h0A, "t3_status_ovf");
      chk(K_OUT, 2'b10, 8'h08, "t3_count_held");
      cyc(1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 8'h00);
      chk(K_OUT, 2'b01, 8'h02, "t3_status_cleared");
      for (int i = 0; i < 8; i++) begin
         chk(K_OUT, 2'b00, 8'h20 + 8'(i), "t3_data");
         pop();
      end
      chk(K_OUT, 2'b10, 8'h00, "t3_count_empty");

      // T4 underflow with simultaneous push, then push+pop at count 3
      cyc(1'b1, 8'h55, 1'b1, 2'b00, 1'b0, 8'h00);
      chk(K_OUT, 2'b10, 8'h01, "t4_count_one");
      chk(K_OUT, 2'b01, 8'h04, "t4_status_udf");
      chk(K_OUT, 2'b00, 8'h55, "t4_data_55");
      cyc(1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 8'h00);
      chk(K_OUT, 2'b01, 8'h00, "t4_status_cleared");
      push(8'h66);
      push(8'h77);
      cyc(1'b1, 8'h88, 1'b1, 2'b00, 1'b0, 8'h00);
      chk(K_OUT, 2'b10, 8'h03, "t4_count_three");
      chk(K_OUT, 2'b00, 8'h66, "t4_data_66");
      pop(); pop(); pop();
      chk(K_OUT, 2'b01, 8'h01, "t4_status_empty");

      // T5 pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) push(8'h30 + 8'(r * 16 + i));
         for (int i = 0; i < 5; i++) begin
            chk(K_OUT, 2'b00, 8'h30 + 8'(r * 16 + i), "t5_data");
            pop();
         end
      end
      chk(K_OUT, 2'b10, 8'h00, "t5_count_zero");

      // T6 irq and flush
      cyc(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 8'h01);
      push(8'hA0); push(8'hA1); push(8'hA2);
      chk(K_IRQ, 2'b00, 8'h00, "t6_irq_below");
      push(8'hA3);
      chk(K_IRQ, 2'b00, 8'h01, "t6_irq_at_level");
      pop();
      chk(K_IRQ, 2'b00, 8'h00, "t6_irq_after_pop");
      push(8'hA4);
      chk(K_IRQ, 2'b00, 8'h01, "t6_irq_again");
      cyc(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 8'h03);
      chk(K_OUT, 2'b11, 8'h03, "t6_ctrl_flush_pending");
      cyc(1'b1, 8'hBB, 1'b0, 2'b00, 1'b0, 8'h00);
      chk(K_OUT, 2'b10, 8'h00, "t6_count_flushed");
      chk(K_IRQ, 2'b00, 8'h00, "t6_irq_flushed");
      chk(K_OUT, 2'b11, 8'h01, "t6_ctrl_after_flush");
      chk(K_OUT, 2'b01, 8'h01, "t6_status_no_ovf");
      chk(K_RDY, 2'b00, 8'h01, "t6_in_ready");

      repeat (2) @(posedge clk);
      if (kind_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", kind_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
